// File: rtl/gcd_calculator_mm.sv
// rtl/gcd_calculator_mm.sv - Avalon-MM binary GCD coprocessor (optional irq via GCD_IRQ_EN)
module gcd_calculator_mm #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [ADDR_W-1:0] csr_address,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);
    localparam int WORDS = WIDTH / 32;
    localparam int KW    = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_NORM, S_ITER, S_DONE} state_t;
    state_t state_q, state_d;

    logic [31:0]      a_reg [WORDS];
    logic [31:0]      b_reg [WORDS];
    logic [WIDTH-1:0] a_full, b_full, x, y, result;
    logic [KW-1:0]    k;
    logic [31:0]      cycles;
    logic             done, zero_in, aborted, busy;
    logic [31:0]      addr;
    logic             ctrl_wr, start_go, abort_go, clr_go, operands_zero, stepping;
    logic [31:0]      rd_data;

    assign addr          = 32'(csr_address);
    assign busy          = (state_q != S_IDLE);
    assign ctrl_wr       = csr_write && (addr == 32'd1);
    // abort takes priority over start when both bits arrive in one write
    assign abort_go      = ctrl_wr && csr_writedata[1] && busy;
    assign start_go      = ctrl_wr && csr_writedata[0] && !csr_writedata[1] && !busy;
    assign clr_go        = ctrl_wr && csr_writedata[2] && !busy;
    assign operands_zero = (a_full == '0) || (b_full == '0);
    assign stepping      = (state_q == S_SHIFT) || (state_q == S_NORM) || (state_q == S_ITER);

    always_comb begin
        a_full = '0;
        b_full = '0;
        for (int w = 0; w < WORDS; w++) begin
            a_full[w*32 +: 32] = a_reg[w];
            b_full[w*32 +: 32] = b_reg[w];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go && !operands_zero) state_d = S_SHIFT;
            S_SHIFT: if (x[0] || y[0]) state_d = S_NORM;
            S_NORM:  if (x[0]) state_d = S_ITER;
            S_ITER:  if (y == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_go) state_d = S_IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < WORDS; w++) begin
                a_reg[w] <= '0;
                b_reg[w] <= '0;
            end
            x       <= '0;
            y       <= '0;
            k       <= '0;
            result  <= '0;
            cycles  <= '0;
            done    <= 1'b0;
            zero_in <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (csr_write && !busy) begin
                for (int w = 0; w < WORDS; w++) begin
                    if (addr == 32'(4 + w))         a_reg[w] <= csr_writedata;
                    if (addr == 32'(4 + WORDS + w)) b_reg[w] <= csr_writedata;
                end
            end
            if (clr_go) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            if (start_go) begin
                x       <= a_full;
                y       <= b_full;
                k       <= '0;
                cycles  <= '0;
                done    <= 1'b0;
                zero_in <= 1'b0;
                aborted <= 1'b0;
                if (operands_zero) begin
                    result  <= a_full | b_full;
                    zero_in <= 1'b1;
                    done    <= 1'b1;
                end
            end
            if (abort_go) begin
                aborted <= 1'b1;
                done    <= 1'b0;
            end else begin
                if (stepping && (cycles != 32'hFFFF_FFFF)) cycles <= cycles + 32'd1;
                case (state_q)
                    S_SHIFT: if (!x[0] && !y[0]) begin
                        x <= x >> 1;
                        y <= y >> 1;
                        k <= k + KW'(1);
                    end
                    S_NORM: if (!x[0]) x <= x >> 1;
                    // x is odd from here on; y odd means a subtract, y even a halving
                    S_ITER: if (y != '0) begin
                        if (!y[0])        y <= y >> 1;
                        else if (x <= y)  y <= y - x;
                        else begin
                            x <= y;
                            y <= x - y;
                        end
                    end
                    S_DONE: begin
                        result <= x << k;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GCD_IRQ_EN
    logic irq_en;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               irq_en <= 1'b0;
        else if (ctrl_wr && !busy)  irq_en <= csr_writedata[3];
    end
    assign irq = done & irq_en;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = 32'hDEAD_BEEF;
        case (addr)
            32'd0:   rd_data = {28'd0, aborted, zero_in, done, busy};
            32'd1:   rd_data = 32'd0;
            32'd2:   rd_data = cycles;
            32'd3:   rd_data = 32'd0;
            default: ;
        endcase
        for (int w = 0; w < WORDS; w++) begin
            if (addr == 32'(4 + w))           rd_data = a_reg[w];
            if (addr == 32'(4 + WORDS + w))   rd_data = b_reg[w];
            if (addr == 32'(4 + 2*WORDS + w)) rd_data = result[w*32 +: 32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      csr_readdata <= '0;
        else if (csr_read) csr_readdata <= rd_data;
    end
endmodule

// File: tb/tb_gcd_calculator_mm.sv
// tb/tb_gcd_calculator_mm.sv - directed and random checks of gcd_calculator_mm against a Euclid model
module tb_gcd_calculator_mm;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [ADDR_W-1:0] csr_address = '0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gcd_calculator_mm #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n), .csr_read(csr_read), .csr_write(csr_write),
        .csr_address(csr_address), .csr_writedata(csr_writedata),
        .csr_readdata(csr_readdata), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clock);
        csr_write = 1'b1; csr_address = ADDR_W'(a); csr_writedata = d;
        @(negedge clock);
        csr_write = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        @(negedge clock);
        csr_read = 1'b1; csr_address = ADDR_W'(a);
        @(negedge clock);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic rd64(input int a, output logic [63:0] d);
        logic [31:0] lo, hi;
        rd(a, lo);
        rd(a + 1, hi);
        d = {hi, lo};
    endtask

    function automatic logic [63:0] model_gcd(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic start_run(input logic [63:0] a, input logic [63:0] b, input logic [31:0] ctrl);
        wr(4, a[31:0]); wr(5, a[63:32]);
        wr(6, b[31:0]); wr(7, b[63:32]);
        wr(1, ctrl);
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] st);
        int n = 0;
        do begin
            rd(0, st);
            n++;
        end while (st[0] && n < 200);
        if (st[0]) check({tag, "_timeout"}, 64'(st[0]), 64'd0);
    endtask

    task automatic run_and_check(input string tag, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] st, cyc;
        logic [63:0] res, exp;
        exp = model_gcd(a, b);
        start_run(a, b, 32'h1);
        wait_idle(tag, st);
        rd64(8, res);
        rd(2, cyc);
        check({tag, "_result"}, res, exp);
        check({tag, "_status"}, 64'(st), (a == 0 || b == 0) ? 64'h6 : 64'h2);
        if (a != 0 && b != 0) check({tag, "_cyc_bound"}, 64'(cyc > 0 && cyc < 2*WIDTH+2), 64'd1);
    endtask

    initial begin
        logic [31:0] st, d, cyc;
        logic [63:0] r, ra, rb, f;

        #1 check("readdata_in_reset", 64'(csr_readdata), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        rd(0, d);   check("reset_status", 64'(d), 64'd0);
        rd(2, d);   check("reset_cycles", 64'(d), 64'd0);
        rd64(8, r); check("reset_result", r, 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        rd(3, d);   check("reserved", 64'(d), 64'd0);
        rd(31, d);  check("unmapped", 64'(d), 64'hDEADBEEF);
        rd(10, d);  check("unmapped_first", 64'(d), 64'hDEADBEEF);

        run_and_check("g48_18", 64'd48, 64'd18);

        start_run(64'd48, 64'd18, 32'h1);
        wr(4, 32'd99);
        @(negedge clock);
        wr(1, 32'h2);
        rd(0, d);   check("abort_status", 64'(d), 64'h8);
        rd(4, d);   check("abort_a_kept", 64'(d), 64'd48);
        rd64(8, r); check("abort_result_kept", r, 64'd6);
        wr(1, 32'h4);
        rd(0, d);   check("clr_done_status", 64'(d), 64'h0);

        start_run(64'h8000000000000000, 64'h0000010000000000, 32'h1);
        wait_idle("pow2", st);
        rd64(8, r); check("pow2_result", r, 64'h0000010000000000);
        rd(2, cyc); check("pow2_cycles", 64'(cyc), 64'd67);

        start_run(64'd0, 64'h1234, 32'h1);
        rd(0, d);   check("zero_status", 64'(d), 64'h6);
        rd64(8, r); check("zero_result", r, 64'h1234);
        rd(2, d);   check("zero_cycles", 64'(d), 64'd0);
        run_and_check("both_zero", 64'd0, 64'd0);

        run_and_check("primes", 64'hFFFFFFFFFFFFFFC5, 64'hFFFFFFFFFFFFFFAD);
        run_and_check("equal", 64'd1000, 64'd1000);

        for (int i = 0; i < 16; i++) begin
            f  = 64'($urandom_range(1, 5000)) << $urandom_range(0, 12);
            ra = {32'h0, $urandom} * f;
            rb = {32'h0, $urandom_range(1, 32'hFFFF)} * f;
            if (ra == 0) ra = f;
            run_and_check($sformatf("rand%0d", i), ra, rb);
        end

        start_run(64'd48, 64'd18, 32'h9);
        wait_idle("irq_run", st);
`ifdef GCD_IRQ_EN
        check("irq_with_done", 64'(irq), 64'd1);
        rd(0, d);
        check("irq_survives_read", 64'(irq), 64'd1);
        wr(1, 32'hC);
        check("irq_cleared", 64'(irq), 64'd0);
`else
        check("irq_tied_low", 64'(irq), 64'd0);
        wr(1, 32'hC);
        check("irq_still_low", 64'(irq), 64'd0);
`endif
        rd(0, d);   check("final_status", 64'(d), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
